// File: rtl/conv_row_endpoint.sv
// PE-side NoC endpoint: spike-gated row MAC into 3x3 membrane potentials.
// Optional LEAK_EN macro enables the leak on non-firing neurons at FIRE.
module conv_row_endpoint #(
   parameter logic [7:0] PE_ADDR_MASK = 8'h0F,
   parameter logic [7:0] DEST_ADDR    = 8'h00,
   parameter int         POT_W        = 16,
   parameter int         THRESH       = 64
`ifdef LEAK_EN
   ,
   parameter int         LEAK         = 1
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [38:0] in_packet,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [38:0] out_packet,
   output logic        drop_pulse,
   output logic        timestep_done
);

   typedef enum logic [2:0] {
      IDLE, CHECK, MAC, FIRE, SEND
   } state_t;

   state_t            state;
   logic [38:0]       pkt_q;
   logic [1:0]        row_q;
   logic [1:0]        c_q;
   logic [POT_W-1:0]  pot [3][3];
   logic [1:0]        cnt [3];

   logic [1:0]        typ;
   logic [7:0]        addr;
   logic [7:0]        k_bits;
   logic [7:0]        r_bits;
   logic              pkt_ok;
   logic [4:0]        ifm_sh;
   logic [9:0]        partial;
   logic [POT_W:0]    sum;
   logic [POT_W-1:0]  mac_pot;
   logic [2:0]        spk;
   logic [7:0]        field [3];
   logic [POT_W-1:0]  next_pot [3];

   always_comb begin
      typ    = pkt_q[38:37];
      addr   = pkt_q[36:29];
      k_bits = addr & PE_ADDR_MASK;
      r_bits = (addr & ~PE_ADDR_MASK) >> 4;
      pkt_ok = (typ == 2'b01) && (k_bits >= 8'd1) &&
               (k_bits <= 8'd3) && (r_bits <= 8'd2);
      // shifting by c lines ifmap[4-c-j] up with tap j
      ifm_sh  = pkt_q[28:24] << c_q;
      partial = '0;
      for (int j = 0; j < 3; j++) begin
         if (ifm_sh[4-j])
            partial = partial + 10'(pkt_q[23-8*j -: 8]);
      end
      sum     = {1'b0, pot[row_q][c_q]} + (POT_W+1)'(partial);
      mac_pot = sum[POT_W] ? '1 : sum[POT_W-1:0];
      for (int c = 0; c < 3; c++) begin
         spk[c]   = pot[row_q][c] >= POT_W'(THRESH);
         field[c] = (pot[row_q][c] > POT_W'(255)) ?
                    8'hFF : pot[row_q][c][7:0];
         if (spk[c])
            next_pot[c] = '0;
         else begin
`ifdef LEAK_EN
            next_pot[c] = (pot[row_q][c] > POT_W'(LEAK)) ?
                          pot[row_q][c] - POT_W'(LEAK) : '0;
`else
            next_pot[c] = pot[row_q][c];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         in_ready      <= 1'b0;
         out_valid     <= 1'b0;
         out_packet    <= '0;
         drop_pulse    <= 1'b0;
         timestep_done <= 1'b0;
         pkt_q         <= '0;
         row_q         <= '0;
         c_q           <= '0;
         for (int r = 0; r < 3; r++) begin
            cnt[r] <= '0;
            for (int c = 0; c < 3; c++)
               pot[r][c] <= '0;
         end
      end else begin
         drop_pulse    <= 1'b0;
         timestep_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  pkt_q    <= in_packet;
                  in_ready <= 1'b0;
                  state    <= CHECK;
               end else
                  in_ready <= 1'b1;
            end
            CHECK: begin
               if (pkt_ok) begin
                  row_q <= r_bits[1:0];
                  c_q   <= '0;
                  state <= MAC;
               end else begin
                  drop_pulse <= 1'b1;
                  in_ready   <= 1'b1;
                  state      <= IDLE;
               end
            end
            MAC: begin
               pot[row_q][c_q] <= mac_pot;
               if (c_q == 2'd2) begin
                  cnt[row_q] <= cnt[row_q] + 2'd1;
                  if (cnt[row_q] == 2'd2)
                     state <= FIRE;
                  else begin
                     in_ready <= 1'b1;
                     state    <= IDLE;
                  end
               end else
                  c_q <= c_q + 2'd1;
            end
            FIRE: begin
               for (int c = 0; c < 3; c++)
                  pot[row_q][c] <= next_pot[c];
               cnt[row_q] <= '0;
               out_packet <= {2'b10, DEST_ADDR, row_q,
                              spk[0], spk[1], spk[2],
                              field[0], field[1], field[2]};
               out_valid  <= 1'b1;
               state      <= SEND;
            end
            SEND: begin
               if (out_ready) begin
                  out_valid     <= 1'b0;
                  timestep_done <= (row_q == 2'd2);
                  in_ready      <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_row_endpoint.sv
// Randomised bench for conv_row_endpoint against an arithmetic model.
// Model tracks the 3x3 potentials and per-row kernel-row counts.
module tb_conv_row_endpoint;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [38:0] in_packet = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [38:0] out_packet;
   logic        drop_pulse;
   logic        timestep_done;

   int checks = 0;
   int errors = 0;
   int mpot [3][3];
   int mcnt [3];

   typedef struct {
      bit          to;
      int          drops;
      bit          drop_late;
      bit          got;
      logic [38:0] pkt;
      bit          stable;
      bit          rdy_low;
      bit          ts;
      bit          ts_late;
      bit          ov_after;
   } obs_t;

   conv_row_endpoint dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_packet     (in_packet),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_packet    (out_packet),
      .drop_pulse    (drop_pulse),
      .timestep_done (timestep_done)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time exceeded");
      $fatal(1, "watchdog");
   end

   task automatic model_reset();
      for (int r = 0; r < 3; r++) begin
         mcnt[r] = 0;
         for (int c = 0; c < 3; c++) mpot[r][c] = 0;
      end
   endtask

   task automatic model_pkt(input logic [38:0] p, output bit drop,
                            output bit has, output logic [38:0] e);
      int typ, k, r, ifm, part, f, w[3];
      bit s[3];
      logic [7:0] fb[3];
      typ = int'(p[38:37]);
      r   = int'(p[36:33]);
      k   = int'(p[32:29]);
      ifm = int'(p[28:24]);
      w[0] = int'(p[23:16]);
      w[1] = int'(p[15:8]);
      w[2] = int'(p[7:0]);
      drop = 0;
      has  = 0;
      e    = '0;
      if (typ != 1 || k < 1 || k > 3 || r > 2) begin
         drop = 1;
         return;
      end
      for (int c = 0; c < 3; c++) begin
         part = 0;
         for (int j = 0; j < 3; j++)
            if (((ifm >> (4 - c - j)) & 1) == 1) part += w[j];
         mpot[r][c] += part;
         if (mpot[r][c] > 65535) mpot[r][c] = 65535;
      end
      mcnt[r]++;
      if (mcnt[r] == 3) begin
         has = 1;
         mcnt[r] = 0;
         for (int c = 0; c < 3; c++) begin
            f = (mpot[r][c] > 255) ? 255 : mpot[r][c];
            fb[c] = 8'(f);
            s[c] = (mpot[r][c] >= 64);
            if (s[c]) mpot[r][c] = 0;
`ifdef LEAK_EN
            else mpot[r][c] = (mpot[r][c] > 1) ? mpot[r][c] - 1 : 0;
`endif
         end
         e = {2'b10, 8'h00, 2'(r), s[0], s[1], s[2],
              fb[0], fb[1], fb[2]};
      end
   endtask

   task automatic xfer(input logic [38:0] p, input int hold,
                       output obs_t o);
      int n;
      o = '{default: 0};
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         o.to = 1;
         return;
      end
      in_valid  = 1'b1;
      in_packet = p;
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         if (drop_pulse) o.drops++;
         n++;
      end while (!out_valid && !in_ready && n < 20);
      if (!out_valid && !in_ready) begin
         o.to = 1;
         return;
      end
      if (!out_valid) begin
         @(negedge clk);
         o.drop_late = drop_pulse;
         return;
      end
      o.got     = 1;
      o.pkt     = out_packet;
      o.stable  = 1;
      o.rdy_low = 1;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         @(negedge clk);
         if (out_packet !== o.pkt || out_valid !== 1'b1) o.stable = 0;
         if (in_ready !== 1'b0) o.rdy_low = 0;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      o.ts       = timestep_done;
      o.ov_after = out_valid;
      @(negedge clk);
      o.ts_late  = timestep_done;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({out_valid, in_ready, drop_pulse, timestep_done} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctl got %b want 0000",
                  {out_valid, in_ready, drop_pulse, timestep_done});
      end
      checks++;
      if (out_packet !== 39'd0) begin
         errors++;
         $display("FAIL reset_pkt got %h want 0", out_packet);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL release_rdy0 got %b want 0", in_ready);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release_rdy1 got %b want 1", in_ready);
      end
      in_valid  = 1'b1;
      in_packet = {2'b01, 8'h01, 5'b11111, 8'd50, 8'd50, 8'd50};
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
         errors++;
         $display("FAIL midmac_rst got %b want 00", {out_valid, in_ready});
      end
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL midmac_rel0 got %b want 0", in_ready);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL midmac_rel1 got %b want 1", in_ready);
      end
   endtask

   task automatic test_drop();
      logic [38:0] pk[3];
      logic [38:0] e;
      bit d, h;
      obs_t o;
      pk[0] = {2'b00, 8'h01, 5'b11111, 24'hFFFFFF};
      pk[1] = {2'b01, 8'h04, 5'b11111, 24'hFFFFFF};
      pk[2] = {2'b01, 8'h31, 5'b11111, 24'hFFFFFF};
      for (int i = 0; i < 3; i++) begin
         model_pkt(pk[i], d, h, e);
         xfer(pk[i], 0, o);
         checks++;
         if (o.to || o.drops != 1 || o.drop_late || o.got || !d) begin
            errors++;
            $display("FAIL drop%0d to=%0d drops=%0d late=%0d out=%0d want 0,1,0,0",
                     i, o.to, o.drops, o.drop_late, o.got);
         end
      end
   endtask

   task automatic test_timestep(input logic [4:0] ifm, input bit first);
      int rs[9] = '{0, 0, 1, 0, 1, 2, 1, 2, 2};
      int ks[9] = '{1, 2, 1, 3, 2, 1, 3, 2, 3};
      int outs, tsn, k;
      logic [38:0] p, e;
      logic [38:0] c45;
      bit d, h;
      obs_t o;
      outs = 0;
      tsn  = 0;
      c45  = {2'b10, 8'h00, 2'd0, 3'b000, 8'd45, 8'd45, 8'd45};
      for (int i = 0; i < 9; i++) begin
         k = ks[i];
         p = {2'b01, 4'(rs[i]), 4'(k), ifm,
              8'(3*k-2), 8'(3*k-1), 8'(3*k)};
         model_pkt(p, d, h, e);
         xfer(p, 0, o);
         checks++;
         if (o.to || o.got != h || o.drops != 0) begin
            errors++;
            $display("FAIL ts_pkt%0d to=%0d out=%0d drops=%0d want out=%0d",
                     i, o.to, o.got, o.drops, h);
         end
         if (h && o.got) begin
            outs++;
            tsn += o.ts + o.ts_late;
            checks++;
            if (o.pkt !== e) begin
               errors++;
               $display("FAIL ts_out%0d got %h want %h", i, o.pkt, e);
            end
            checks++;
            if (o.ts != (rs[i] == 2) || o.ov_after) begin
               errors++;
               $display("FAIL ts_done%0d got ts=%0d ov=%0d want ts=%0d ov=0",
                        i, o.ts, o.ov_after, rs[i] == 2);
            end
            if (first && outs == 1) begin
               checks++;
               if (o.pkt !== c45) begin
                  errors++;
                  $display("FAIL ts_const got %h want %h", o.pkt, c45);
               end
            end
         end
      end
      checks++;
      if (outs != 3 || tsn != 1) begin
         errors++;
         $display("FAIL ts_count outs=%0d done=%0d want 3,1", outs, tsn);
      end
   endtask

   task automatic test_backpressure();
      logic [38:0] p, e;
      bit d, h;
      obs_t o;
      for (int k = 1; k <= 3; k++) begin
         p = {2'b01, 4'd1, 4'(k), 5'($urandom), 24'($urandom)};
         model_pkt(p, d, h, e);
         xfer(p, 10, o);
         checks++;
         if (o.to || o.got != h) begin
            errors++;
            $display("FAIL bp_flow%0d to=%0d out=%0d want %0d",
                     k, o.to, o.got, h);
         end
         if (h) begin
            checks++;
            if (!o.stable || !o.rdy_low || o.pkt !== e) begin
               errors++;
               $display("FAIL bp_hold stable=%0d rdylow=%0d got %h want %h",
                        o.stable, o.rdy_low, o.pkt, e);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [38:0] p, e;
      logic [1:0] ty;
      logic [3:0] r, k;
      bit d, h;
      obs_t o;
      int hold;
      for (int i = 0; i < 80; i++) begin
         ty = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b01;
         r  = ($urandom_range(0, 9) == 0) ? 4'd3 :
              4'($urandom_range(0, 2));
         k  = ($urandom_range(0, 9) == 0) ? 4'd0 :
              4'($urandom_range(1, 3));
         p  = {ty, r, k, 5'($urandom), 24'($urandom)};
         hold = $urandom_range(0, 3);
         model_pkt(p, d, h, e);
         xfer(p, hold, o);
         checks++;
         if (o.to || o.got != h || o.drops != int'(d)) begin
            errors++;
            $display("FAIL rnd_flow%0d to=%0d out=%0d drops=%0d want %0d,%0d",
                     i, o.to, o.got, o.drops, h, d);
         end
         if (h && o.got) begin
            checks++;
            if (o.pkt !== e || o.ts != (r == 4'd2) || o.ts_late) begin
               errors++;
               $display("FAIL rnd_out%0d got %h ts=%0d want %h ts=%0d",
                        i, o.pkt, o.ts, e, r == 4'd2);
            end
            if (hold > 0) begin
               checks++;
               if (!o.stable || !o.rdy_low) begin
                  errors++;
                  $display("FAIL rnd_hold%0d stable=%0d rdylow=%0d want 1,1",
                           i, o.stable, o.rdy_low);
               end
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_drop();
      test_timestep(5'b11111, 1'b1);
      test_timestep(5'b11111, 1'b0);
      test_timestep(5'b10000, 1'b0);
      test_backpressure();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
